prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WIDTH, 32, instruction word width; only 32 is supported.
REQ-002 Parameter ROM_SIZE, 10, instruction-memory address width in words (depth 2^ROM_SIZE).
REQ-003 Parameter TIMEOUT, 100000, maximum number of clk cycles allowed between received bytes.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a load session.
REQ-007 byte_valid  in  1  single-cycle strobe from the serial receiver; no backpressure is possible.
REQ-008 byte_data  in  8  received byte; valid only when byte_valid=1.
REQ-009 imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
REQ-010 imem_addr  out  ROM_SIZE  word address of the write.
REQ-011 imem_wdata  out  WIDTH  instruction word to write.
REQ-012 cpu_hold  out  1  holds the CPU in reset while a load is in progress.
REQ-013 done  out  1  last load completed with a good checksum.
REQ-014 error  out  1  last load failed.

Function
REQ-015 The byte stream SHALL be: length N (16-bit, little-endian, 2 bytes), then 4N data bytes (each word little-endian), then 1 checksum byte equal to the XOR of all data bytes.
REQ-016 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
REQ-017 start in any state SHALL go to LEN_LO, clear the address, byte counter, checksum, done and error, and assert cpu_hold from the next cycle.
REQ-018 start SHALL win over a byte_valid in the same cycle; that byte is discarded.
REQ-019 byte_valid in IDLE, DONE or ERR SHALL be ignored.
REQ-020 After LEN_HI, N=0 SHALL go directly to CHECK; N>2^ROM_SIZE SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-021 In DATA the block SHALL pack byte k of each word into bits [8k+7:8k], with k running from 0 to 3.
REQ-022 On the 4th byte of a word, imem_we SHALL pulse high for exactly one cycle, on the cycle after that byte.
REQ-023 During that pulse, imem_addr and imem_wdata SHALL be stable and carry the word index (0..N-1) and the packed word.
REQ-024 imem_addr SHALL increment after each write and SHALL NOT wrap; N is bounded by REQ-020.
REQ-025 After word N-1 is written, the FSM SHALL go to CHECK.
REQ-026 In CHECK, a matching checksum byte SHALL go to DONE and a mismatching byte SHALL go to ERR.
REQ-027 An idle counter SHALL clear on every accepted byte and on start; reaching TIMEOUT in LEN_LO, LEN_HI, DATA or CHECK SHALL go to ERR.
REQ-028 DONE SHALL set done=1 and cpu_hold=0, held until the next start.
REQ-029 ERR SHALL set error=1 and keep cpu_hold=1, held until the next start.
REQ-030 Words already written before an error SHALL NOT be rolled back.
REQ-031 imem_we SHALL be 0 in every state except the single write cycle.

Reset
REQ-032 Asserting rst SHALL immediately force the IDLE state and the outputs imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0.
REQ-033 Asserting rst SHALL also clear all counters and the checksum.
REQ-034 rst asserted mid-load SHALL abort the session without a partial write pulse.
REQ-035 After rst the CPU SHALL run from the existing memory contents.

Structure
REQ-036 The loader state enum and the constants LEN_BYTES=2 and BYTES_PER_WORD=4 SHALL reside in the shared CPU package.
REQ-037 Byte-to-word packing and the write pulse SHALL be a sub-module, loader_word_assembler, with inputs clear, byte_valid and byte_data and outputs word and word_valid.
REQ-038 The FSM, idle counter and checksum SHALL reside in prog_loader.

Verification
REQ-039 Load of 2 words: start; then bytes 02 00, 13 05 10 00, 73 00 00 00, checksum 0x75. Required: writes addr0=0x00100513 and addr1=0x00000073; done=1; cpu_hold falls 1 cycle after the checksum byte.
REQ-040 Bad checksum: same stream with checksum 0x00. Required: both words written; error=1; done=0; cpu_hold stays 1.
REQ-041 Oversize length: N=0x0401 with ROM_SIZE=10. Required: ERR after the 2nd byte; no imem_we pulse.
REQ-042 Timeout: start, 3 data bytes, then silence for TIMEOUT cycles. Required: error=1; no write pulse for the partial word.
REQ-043 Restart: start mid-DATA with a byte_valid in the same cycle. Required: that byte is dropped; address restarts at 0; error and done cleared.
REQ-044 Reset mid-load: rst asserted during the 3rd byte of word 1. Required: all outputs 0 within the same cycle; later bytes ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader state encoding and stream framing constants
package prog_loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } loader_state_t;
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/prog_loader_word_assembler.sv
// loader_word_assembler: packs little-endian bytes into words and pulses word_valid once per word
module loader_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_valid
);
    logic [1:0]       k_q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    // byte k lands in bits [8k+7:8k]; the pulse follows the last byte so the word is complete and stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            k_q     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_valid && (k_q == 2'(BYTES_PER_WORD - 1));
            if (byte_valid) begin
                word_q[8*k_q +: 8] <= byte_data;
                k_q                <= k_q + 2'd1;
            end
        end
    end
    assign word       = word_q;
    assign word_valid = valid_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: serial boot loader writing a length-framed, XOR-checked program into instruction memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ROM_SIZE = 10,
    parameter int TIMEOUT  = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                imem_we,
    output logic [ROM_SIZE-1:0] imem_addr,
    output logic [WIDTH-1:0]    imem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);
    localparam int              IW    = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   TMO   = IW'(TIMEOUT);
    localparam logic [16:0]     MAX_N = 17'(1) << ROM_SIZE;

    loader_state_t       state_q, state_d;
    logic [15:0]         len_q;
    logic [17:0]         byte_cnt_q;
    logic [7:0]          csum_q;
    logic [IW-1:0]       idle_q;
    logic [ROM_SIZE-1:0] addr_q;
    logic                active, acc, last_byte;
    logic [15:0]         n;

    assign active    = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
    assign acc       = byte_valid && active && !start;
    assign n         = {byte_data, len_q[7:0]};
    assign last_byte = byte_cnt_q == {len_q - 16'd1, 2'b11};

    loader_word_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_valid (acc && state_q == DATA),
        .byte_data  (byte_data),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: start beats everything, an accepted byte beats the idle timeout
    always_comb begin
        state_d = state_q;
        if (start) state_d = LEN_LO;
        else if (acc) begin
            case (state_q)
                LEN_LO:  state_d = LEN_HI;
                LEN_HI:  state_d = (n == 16'd0) ? CHECK : ({1'b0, n} > MAX_N) ? ERR : DATA;
                DATA:    state_d = last_byte ? CHECK : DATA;
                CHECK:   state_d = (byte_data == csum_q) ? DONE : ERR;
                default: state_d = state_q;
            endcase
        end else if (active && idle_q == TMO) state_d = ERR;
    end

    // outputs decoded from state so reset clears them immediately
    always_comb begin
        cpu_hold = active || state_q == ERR;
        done     = state_q == DONE;
        error    = state_q == ERR;
    end

    // length, byte count, checksum, idle counter and write address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            idle_q     <= '0;
            addr_q     <= '0;
        end else if (start) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            idle_q     <= '0;
            addr_q     <= '0;
        end else begin
            if (acc || !active) idle_q <= '0;
            else if (idle_q != TMO) idle_q <= idle_q + 1'b1;
            if (acc && state_q == LEN_LO) len_q[7:0] <= byte_data;
            if (acc && state_q == LEN_HI) len_q[15:8] <= byte_data;
            if (acc && state_q == DATA) begin
                byte_cnt_q <= byte_cnt_q + 18'd1;
                csum_q     <= csum_q ^ byte_data;
            end
            if (imem_we && addr_q != '1) addr_q <= addr_q + 1'b1;
        end
    end
    assign imem_addr = addr_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for the serial program loader
module tb_prog_loader;
    localparam int TMO = 40;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        imem_we, cpu_hold, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;

    typedef struct packed {logic [9:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  n_pass = 0, n_chk = 0, we_cnt = 0, w0 = 0;

    always #5 clk = ~clk;

    prog_loader #(.WIDTH(32), .ROM_SIZE(10), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) chk("unexp_we", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("we_addr", 32'(imem_addr), 32'(mon_e.a));
                chk("we_data", imem_wdata, mon_e.d);
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] a, input logic [31:0] w, input bit wr);
        if (wr) exp_q.push_back('{a: a, d: w});
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
    endtask

    initial begin
        #1;
        outs_zero("rst");
        tick(2);
        rst = 1'b0;

        pulse_start;
        chk("hold_start", 32'(cpu_hold), 32'd1);
        send(8'h02); send(8'h00);
        send_word(10'd0, 32'h00100513, 1'b1);
        send_word(10'd1, 32'h00000073, 1'b1);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h75;
        chk("hold_pre", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("done_good", 32'(done), 32'd1);
        chk("hold_post", 32'(cpu_hold), 32'd0);
        chk("err_good", 32'(error), 32'd0);
        tick(2);
        chk("sb_good", 32'(exp_q.size()), 32'd0);

        pulse_start;
        chk("done_clr", 32'(done), 32'd0);
        send(8'h02); send(8'h00);
        send_word(10'd0, 32'h00100513, 1'b1);
        send_word(10'd1, 32'h00000073, 1'b1);
        send(8'h00);
        chk("bad_err", 32'(error), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        tick(2);
        chk("sb_bad", 32'(exp_q.size()), 32'd0);

        pulse_start;
        chk("err_clr", 32'(error), 32'd0);
        w0 = we_cnt;
        send(8'h01);
        chk("big_mid", 32'(error), 32'd0);
        send(8'h04);
        chk("big_err", 32'(error), 32'd1);
        tick(3);
        chk("big_we", 32'(we_cnt - w0), 32'd0);

        pulse_start;
        send(8'h02); send(8'h00);
        w0 = we_cnt;
        send(8'h13); send(8'h05); send(8'h10);
        tick(TMO - 3);
        chk("tmo_early", 32'(error), 32'd0);
        tick(6);
        chk("tmo_err", 32'(error), 32'd1);
        chk("tmo_hold", 32'(cpu_hold), 32'd1);
        chk("tmo_we", 32'(we_cnt - w0), 32'd0);

        pulse_start;
        send(8'h02); send(8'h00);
        send_word(10'd0, 32'h00100513, 1'b1);
        send(8'h73);
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("rs_err", 32'(error), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_hold", 32'(cpu_hold), 32'd1);
        send(8'h02); send(8'h00);
        send_word(10'd0, 32'h00100513, 1'b1);
        send_word(10'd1, 32'h00000073, 1'b1);
        send(8'h75);
        chk("rs_done2", 32'(done), 32'd1);
        tick(2);
        chk("sb_rs", 32'(exp_q.size()), 32'd0);

        pulse_start;
        send(8'h02); send(8'h00);
        send_word(10'd0, 32'h00100513, 1'b1);
        send(8'h73); send(8'h00);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        rst        = 1'b1;
        #1;
        outs_zero("mid");
        @(negedge clk);
        byte_valid = 1'b0;
        rst        = 1'b0;
        w0 = we_cnt;
        send(8'h00); send(8'h75);
        tick(3);
        chk("mid_we", 32'(we_cnt - w0), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_hold", 32'(cpu_hold), 32'd0);
        chk("mid_err", 32'(error), 32'd0);
        chk("sb_mid", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
